// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: issues one word-aligned data-memory request per op,
// formats store lanes and load results, and flags misaligned/illegal ops and load timeouts.
package mem_lsu_pkg;
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
  } mem_resp_t;
endpackage

// state  | meaning
// IDLE   | waiting for lsu_valid
// REQ    | request on the bus until ready
// WAIT   | load accepted, waiting for rvalid or timeout
// RESP   | one-cycle lsu_done pulse
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_exc,
  output logic        lsu_err,
  output mem_req_t    req,
  input  mem_resp_t   resp
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic        op_bad;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // 011/110/111 are never legal; LBU/LHU encodings have no store form
  always_comb begin
    op_bad = (lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11) ||
             (lsu_funct3[2] && lsu_we) ||
             ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
             ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = lsu_wdata;
    case (lsu_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << lsu_addr[1:0];
        st_wdata = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << lsu_addr[1:0];
        st_wdata = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = resp.rdata[{op_off, 3'b000} +: 8];
    ld_half = resp.rdata[{op_off[1], 4'b0000} +: 16];
    case (op_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = resp.rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (lsu_valid) state_next = op_bad ? S_RESP : S_REQ;
      S_REQ:  if (resp.ready) state_next = req.we ? S_RESP : S_WAIT;
      S_WAIT: if (resp.rvalid || (cnt == TO_LAST)) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_done  = (state == S_RESP);
    lsu_stall = lsu_valid && !lsu_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req       <= '0;
      cnt       <= '0;
      op_f3     <= '0;
      op_off    <= '0;
      lsu_rdata <= '0;
      lsu_exc   <= 1'b0;
      lsu_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (lsu_valid) begin
          lsu_rdata <= '0;
          if (op_bad) begin
            lsu_exc <= 1'b1;
          end else begin
            req.valid <= 1'b1;
            req.we    <= lsu_we;
            req.addr  <= {lsu_addr[31:2], 2'b00};
            req.be    <= lsu_we ? st_be : 4'b0000;
            req.wdata <= lsu_we ? st_wdata : 32'b0;
            op_f3     <= lsu_funct3;
            op_off    <= lsu_addr[1:0];
          end
        end
        S_REQ: if (resp.ready) begin
          req.valid <= 1'b0;
          req.we    <= 1'b0;
          req.be    <= 4'b0000;
          req.wdata <= 32'b0;
          cnt       <= '0;
        end
        S_WAIT: begin
          if (resp.rvalid) begin
            lsu_rdata <= ld_data;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == TO_LAST) lsu_err <= 1'b1;
          end
        end
        S_RESP: begin
          lsu_rdata <= '0;
          lsu_exc   <= 1'b0;
          lsu_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: a bench-side memory answers requests, and a byte-level
// model of the same memory predicts every load result, latency and error flag.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_done, lsu_exc, lsu_err;
  logic [31:0] lsu_rdata;
  mem_req_t    req;
  mem_resp_t   resp;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_exc(lsu_exc), .lsu_err(lsu_err),
    .req(req), .resp(resp)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] phys [16];
  logic [7:0]  model [64];
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit op_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (we) begin
      if (f3 > 3'd2) return 1'b0;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b0;
    end
    n = 1 << f3[1:0];
    return (a % n) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int n;
    v = 0;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) v = v | (longint'(model[a[5:0] + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // rv_dly >= TIMEOUT means the responder never answers
  task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rdy_dly, input int rv_dly);
    bit legal, exp_err, done_seen;
    int n, exp_lat, req_cycles, rv_cycle;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_be, rd_idx;
    mem_req_t    first;
    legal = op_legal(we, f3, a);
    n = 1 << f3[1:0];
    exp_be = '0;
    exp_wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= a[1:0] && i < a[1:0] + n) exp_be[i] = 1'b1;
      exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    exp_err = legal && !we && rv_dly >= TIMEOUT;
    if (!legal)       exp_lat = 1;
    else if (we)      exp_lat = 2 + rdy_dly;
    else if (exp_err) exp_lat = 2 + rdy_dly + TIMEOUT;
    else              exp_lat = 3 + rdy_dly + rv_dly;
    exp_rd = (!legal || exp_err || we) ? 32'h0 : model_load(f3, a);
    req_cycles = 0;
    rv_cycle = -1;
    rd_idx = '0;
    done_seen = 1'b0;
    first = '0;

    lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd; lsu_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (lsu_done) begin
        chk("latency", k, exp_lat);
        chk("exc", lsu_exc, !legal);
        chk("err", lsu_err, exp_err);
        chk("stall_at_done", lsu_stall, 0);
        if (!legal || !we) chk("rdata", lsu_rdata, exp_rd);
        last_rdata = lsu_rdata;
        done_seen = 1'b1;
        break;
      end
      chk("stall", lsu_stall, 1);
      if (!req.valid) begin
        chk("req_idle", {req.we, req.be, req.wdata}, 0);
      end else begin
        chk("req_on_illegal", req.valid, legal);
        req_cycles++;
        if (req_cycles == 1) first = req;
        else chk("req_hold", req, first);
        chk("req_addr", req.addr, {a[31:2], 2'b00});
        chk("req_we", req.we, we);
        if (we) begin
          chk("req_be", req.be, exp_be);
          chk("req_wdata", req.wdata, exp_wd);
        end
      end
      resp.ready = req.valid && (req_cycles > rdy_dly);
      if (resp.ready) begin
        if (req.we) begin
          for (int i = 0; i < 4; i++)
            if (req.be[i]) phys[req.addr[5:2]][8*i +: 8] = req.wdata[8*i +: 8];
        end else begin
          rv_cycle = k + 1 + rv_dly;
          rd_idx = req.addr[5:2];
        end
      end
      if (k == rv_cycle) begin
        resp.rvalid = 1'b1;
        resp.rdata  = phys[rd_idx];
      end else if (rv_cycle < 0 && $urandom_range(0, 2) == 0) begin
        resp.rvalid = 1'b1;
        resp.rdata  = $urandom;
      end else begin
        resp.rvalid = 1'b0;
        resp.rdata  = $urandom;
      end
      @(negedge clk);
    end
    chk("done_seen", done_seen, 1);
    if (legal && we)
      for (int i = 0; i < n; i++) model[a[5:0] + i] = wd[8*i +: 8];

    // stale response while finishing and idling must not produce another done
    lsu_valid = 1'b0;
    resp.ready = 1'b0;
    resp.rvalid = 1'b1;
    resp.rdata = $urandom;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("done_once", lsu_done, 0);
      chk("idle_valid", req.valid, 0);
    end
    resp.rvalid = 1'b0;
  endtask

  task automatic reset_mid_wait();
    lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h18; lsu_wdata = '0; lsu_valid = 1'b1;
    resp.ready = 1'b1; resp.rvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_seen", req.valid, 1);
    @(negedge clk);
    resp.ready = 1'b0;
    #2;
    rst = 1'b0;
    lsu_valid = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_exc_err", {lsu_exc, lsu_err}, 0);
    chk("rst_stall", lsu_stall, 0);
    @(negedge clk);
    rst = 1'b1;
    resp.rvalid = 1'b1;
    resp.rdata = $urandom;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_no_done", lsu_done, 0);
      chk("rst_no_req", req.valid, 0);
    end
    resp.rvalid = 1'b0;
  endtask

  initial begin
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a, r;
    int          rv, pick;
    logic [2:0]  ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    for (int w = 0; w < 16; w++) begin
      phys[w] = $urandom;
      for (int b = 0; b < 4; b++) model[4*w + b] = phys[w][8*b +: 8];
    end
    rst = 1'b0;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0; lsu_wdata = '0;
    resp = '0;
    #1;
    chk("reset_req", req, 0);
    chk("reset_outs", {lsu_done, lsu_exc, lsu_err, lsu_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
    run_op(1'b1, 3'b000, 32'h13, 32'h000000A5, 0, 0);
    run_op(1'b0, 3'b000, 32'h13, 32'h0, 0, 0);
    chk("lb_13", last_rdata, 32'hFFFFFFA5);
    run_op(1'b0, 3'b100, 32'h13, 32'h0, 0, 0);
    chk("lbu_13", last_rdata, 32'h000000A5);
    run_op(1'b0, 3'b001, 32'h12, 32'h0, 0, 0);
    chk("lh_12", last_rdata, 32'hFFFFA5AD);
    run_op(1'b0, 3'b101, 32'h10, 32'h0, 0, 0);
    chk("lhu_10", last_rdata, 32'h0000BEEF);
    run_op(1'b0, 3'b010, 32'h02, 32'h0, 0, 0);
    run_op(1'b1, 3'b001, 32'h01, 32'h1234, 0, 0);
    run_op(1'b0, 3'b011, 32'h10, 32'h0, 0, 0);
    run_op(1'b1, 3'b010, 32'h20, 32'h5A5A_0F0F, 3, 0);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, 99);
    run_op(1'b0, 3'b010, 32'h14, 32'h0, 1, TIMEOUT - 1);
    reset_mid_wait();
    run_op(1'b0, 3'b010, 32'h18, 32'h0, 0, 0);

    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_codes[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      pick = $urandom_range(0, 19);
      rv = (pick == 19) ? 99 : (pick == 18) ? TIMEOUT - 1 : pick % 4;
      r = $urandom;
      run_op(we, f3, a, r, $urandom_range(0, 3), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit for the MEM pipeline stage and the initiator side of the mem_req_t/mem_resp_t data-memory interface.
- Turns a RISC-V load/store (funct3, byte address, store data) into one word-aligned request with byte enables and lane-replicated write data.
- Waits for the read response, then sign- or zero-extends the selected lane.
- Stalls the pipeline until the access completes, and flags misaligned accesses, illegal width encodings and response timeouts.

Parameters:
TIMEOUT, 16, cycles waited in WAIT for resp.rvalid before aborting the load (must be at least 1).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
lsu_valid  input  1  memory op present; held stable with all lsu_* inputs until lsu_done.
lsu_we  input  1  1=store, 0=load.
lsu_funct3  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
lsu_addr  input  32  byte address.
lsu_wdata  input  32  store data, right-aligned.
lsu_stall  output  1  combinational: lsu_valid & ~lsu_done.
lsu_done  output  1  registered, one-cycle completion pulse.
lsu_rdata  output  32  formatted load result; valid while lsu_done=1.
lsu_exc  output  1  with lsu_done: misaligned address or illegal funct3.
lsu_err  output  1  with lsu_done: load response timeout.
req  output  mem_req_t  valid, we, addr, be, wdata to data memory; all fields registered.
resp  input  mem_resp_t  ready, rdata, rvalid from data memory.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timeout counter=0. All req fields, lsu_done, lsu_rdata, lsu_exc and lsu_err are 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, lsu_valid=1, legal op: latch the op, go to REQ.
- IDLE, illegal op: go to RESP with lsu_exc=1, lsu_rdata=0, and issue no request.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: 011 or 110 or 111, or 100/101 with lsu_we=1.
- REQ: req.valid=1, req.addr={addr[31:2],2'b00}. A request is accepted on an edge where resp.ready=1.
  - Accepted store: go to RESP.
  - Accepted load: go to WAIT, clear the timeout counter.
  - resp.ready=0: stay in REQ with every req field held unchanged.
- WAIT, resp.rvalid=1: capture the formatted resp.rdata into lsu_rdata, go to RESP.
- WAIT, no rvalid: increment the counter. When it reaches TIMEOUT, go to RESP with lsu_err=1, lsu_rdata=0.
- RESP: lsu_done=1 for exactly one cycle, then IDLE. lsu_valid is ignored in RESP; the next op is sampled in the following IDLE cycle.
- Outside REQ: req.valid, req.we, req.be and req.wdata are 0.
- resp.rvalid outside WAIT is ignored. This includes a stale response arriving after reset.
- Store formatting, with off=addr[1:0]:
  - SB: be=4'b0001<<off, wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<off, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata unchanged.
- Load formatting:
  - LB/LBU: rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU: rdata[16*off[1]+:16], sign- or zero-extended.
  - LW: rdata unchanged.
- Latency against a zero-wait responder (ready=1, rvalid one cycle after accept), counting the issue cycle as cycle 0:
  - Store: lsu_done in cycle 2.
  - Load: lsu_done in cycle 3.
  - Illegal op: lsu_done in cycle 1.
- Reset mid-operation: the transaction is abandoned, no lsu_done is produced, and the block returns to IDLE.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF, ready=1 -> cycle 1: req.valid=1, we=1, addr 0x10, be=1111, wdata 0xDEADBEEF; cycle 2: lsu_done=1; lsu_stall high in cycles 0-1.
- SB addr 0x13, data 0x000000A5 -> be=1000, wdata 0xA5A5A5A5, memory word becomes 0xA5ADBEEF. Then loads from that word:
  - LB 0x13 -> lsu_rdata 0xFFFFFFA5.
  - LBU 0x13 -> 0x000000A5.
  - LH 0x12 -> 0xFFFFA5AD.
  - LHU 0x10 -> 0x0000BEEF.
  - Each load completes with lsu_done in cycle 3.
- LW 0x02, then SH 0x01, then funct3=011 -> req.valid never asserted; lsu_done=1, lsu_exc=1, lsu_rdata=0 in cycle 1 for each.
- SW with resp.ready=0 for 3 cycles, then 1 -> req fields bit-identical across all 4 REQ cycles; lsu_done exactly 1 cycle after the accept edge; lsu_stall high throughout.
- LW, rvalid never asserted, TIMEOUT=16 -> lsu_done=1, lsu_err=1, lsu_rdata=0 after 16 WAIT cycles. A late rvalid is then ignored and no second lsu_done is produced.
- rst=0 pulsed while in WAIT, rvalid after reset release -> req and lsu_* outputs are 0 immediately (asynchronous), no lsu_done, and the next op runs with normal latency.
